// File: rtl/dmem_arbiter_pkg.sv
// Purpose : shared defaults for the round-robin data-memory arbiter.
// Contents: default NUM_PE / DATA_W / ADDR_W / DEPTH and the conflict counter width.
package dmem_arbiter_pkg;

   localparam int unsigned DEF_NUM_PE = 2;
   localparam int unsigned DEF_DATA_W = 32;
   localparam int unsigned DEF_ADDR_W = 32;
   localparam int unsigned DEF_DEPTH  = 1024;
   localparam int unsigned CNT_W      = 16;

endpackage

// File: rtl/rr_arbiter.sv
// Purpose : combinational round-robin selector; first requester at or above ptr,
//           wrapping past NUM_PE-1 to 0.
// Ports   : req     - per-PE request vector
//           ptr     - current highest-priority PE index
//           grant_c - one-hot grant (combinational)
//           idx_c   - index of the granted PE (combinational)
//           valid_c - a grant was issued this cycle (combinational)
module rr_arbiter
   import dmem_arbiter_pkg::*;
#(
   parameter int unsigned NUM_PE = DEF_NUM_PE,
   localparam int unsigned PTR_W = $clog2(NUM_PE)
) (
   input  logic [NUM_PE-1:0] req,
   input  logic [PTR_W-1:0]  ptr,
   output logic [NUM_PE-1:0] grant_c,
   output logic [PTR_W-1:0]  idx_c,
   output logic              valid_c
);

   // Two passes: requesters at/above ptr first, then the wrapped-around low indices.
   always_comb begin
      grant_c = '0;
      idx_c   = '0;
      valid_c = 1'b0;
      for (int i = 0; i < int'(NUM_PE); i++) begin
         if (!valid_c && req[i] && (PTR_W'(i) >= ptr)) begin
            grant_c[i] = 1'b1;
            idx_c      = PTR_W'(i);
            valid_c    = 1'b1;
         end
      end
      for (int i = 0; i < int'(NUM_PE); i++) begin
         if (!valid_c && req[i]) begin
            grant_c[i] = 1'b1;
            idx_c      = PTR_W'(i);
            valid_c    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Purpose : shares one single-port synchronous data memory among NUM_PE
//           processing elements with round-robin arbitration.
// Ports   : clk, rst (async active-low)
//           req/we/addr/wdata - per-PE access requests (addr/wdata flattened)
//           stall             - requesting PE was not granted this cycle
//           rdata/rvalid      - read data and one-hot owner, one cycle after grant
//           conflict_cnt      - saturating count of cycles with 2+ requests
module dmem_arbiter
   import dmem_arbiter_pkg::*;
#(
   parameter int unsigned NUM_PE = DEF_NUM_PE,
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned ADDR_W = DEF_ADDR_W,
   parameter int unsigned DEPTH  = DEF_DEPTH
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_PE-1:0]          req,
   input  logic [NUM_PE-1:0]          we,
   input  logic [NUM_PE*ADDR_W-1:0]   addr,
   input  logic [NUM_PE*DATA_W-1:0]   wdata,
   output logic [NUM_PE-1:0]          stall,
   output logic [DATA_W-1:0]          rdata,
   output logic [NUM_PE-1:0]          rvalid,
   output logic [CNT_W-1:0]           conflict_cnt
);

   localparam int unsigned PTR_W = $clog2(NUM_PE);
   localparam int unsigned IDX_W = $clog2(DEPTH);

   logic [PTR_W-1:0]  ptr;
   logic [PTR_W-1:0]  gnt_idx;
   logic [NUM_PE-1:0] grant;
   logic              gnt_valid;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic              sel_we;
   logic [IDX_W-1:0]  word_idx;
   logic              multi_req;
   logic              unused_addr_bits;

   logic [DATA_W-1:0] mem [DEPTH];

   rr_arbiter #(.NUM_PE(NUM_PE)) u_rr_arbiter (
      .req     (req),
      .ptr     (ptr),
      .grant_c (grant),
      .idx_c   (gnt_idx),
      .valid_c (gnt_valid)
   );

   assign stall = req & ~grant;

   // Route the granted PE's request onto the single memory port.
   always_comb begin
      sel_addr  = '0;
      sel_wdata = '0;
      sel_we    = 1'b0;
      for (int i = 0; i < int'(NUM_PE); i++) begin
         if (grant[i]) begin
            sel_addr  = addr[i*ADDR_W +: ADDR_W];
            sel_wdata = wdata[i*DATA_W +: DATA_W];
            sel_we    = we[i];
         end
      end
   end

   // Word index ignores the byte offset and wraps above the array size.
   assign word_idx         = sel_addr[IDX_W+1:2];
   assign unused_addr_bits = ^{sel_addr[1:0], sel_addr[ADDR_W-1:IDX_W+2]};

   // req & (req-1) is non-zero exactly when two or more bits are set.
   assign multi_req = |(req & (req - NUM_PE'(1)));

   // Storage is not reset; writes are held off while reset is asserted.
   always_ff @(posedge clk) begin
      if (rst && gnt_valid && sel_we) begin
         mem[word_idx] <= sel_wdata;
      end
   end

   // Pointer, read return path and conflict counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr          <= '0;
         rdata        <= '0;
         rvalid       <= '0;
         conflict_cnt <= '0;
      end else begin
         rvalid <= '0;
         if (gnt_valid) begin
            ptr <= (gnt_idx == PTR_W'(NUM_PE - 1)) ? '0 : gnt_idx + PTR_W'(1);
            if (!sel_we) begin
               rdata  <= mem[word_idx];
               rvalid <= grant;
            end
         end
         if (multi_req && (conflict_cnt != '1)) begin
            conflict_cnt <= conflict_cnt + CNT_W'(1);
         end
      end
   end

endmodule
